// File: rtl/axmul_wb_sweeper_pkg.sv
// Shared types and constants for the approximate-multiplier Wishbone sweeper.
// Holds the FSM state encoding, the responder register offsets and the statistic widths.
package axmul_wb_sweeper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [31:0] OPND_OFS = 32'd0;
    localparam logic [31:0] PROD_OFS = 32'd4;

    localparam int CNT_W = 17;
    localparam int SUM_W = 32;
    localparam int ERR_W = 16;

    function automatic logic [ERR_W-1:0] abs_diff(input logic [ERR_W-1:0] x,
                                                  input logic [ERR_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/axmul_err_acc.sv
// Error statistics for one checked pair: |a*b - returned|, mismatch count, sum and max.
// Updates on the single CHK cycle; clr wipes everything when a new sweep begins.
module axmul_err_acc
    import axmul_wb_sweeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_chk,
    input  logic [7:0]       i_a,
    input  logic [7:0]       i_b,
    input  logic [15:0]      i_prod,
    output logic [CNT_W-1:0] o_mismatch_cnt,
    output logic [SUM_W-1:0] o_err_sum,
    output logic [ERR_W-1:0] o_err_max
);

    logic [15:0]      w_exact;
    logic [ERR_W-1:0] w_diff;

    assign w_exact = {8'd0, i_a} * {8'd0, i_b};
    assign w_diff  = abs_diff(w_exact, i_prod);

    // Sum cannot wrap: 65536 pairs of at most 65535 each still fit in 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mismatch_cnt <= '0;
            o_err_sum      <= '0;
            o_err_max      <= '0;
        end else if (i_clr) begin
            o_mismatch_cnt <= '0;
            o_err_sum      <= '0;
            o_err_max      <= '0;
        end else if (i_chk) begin
            if (w_diff != '0) begin
                o_mismatch_cnt <= o_mismatch_cnt + CNT_W'(1);
            end
            o_err_sum <= o_err_sum + SUM_W'(w_diff);
            if (w_diff > o_err_max) begin
                o_err_max <= w_diff;
            end
        end
    end

endmodule

// File: rtl/axmul_wb_sweeper.sv
// Sweeps every (a,b) operand pair through a Wishbone multiplier responder and accumulates error stats.
// Per pair: write, one idle gap, read, CHK, one re-arm cycle plus responder waits; a missing ack times out to ERR.
module axmul_wb_sweeper
    import axmul_wb_sweeper_pkg::*;
#(
    parameter logic [7:0] A_LAST  = 8'd255,
    parameter logic [7:0] B_LAST  = 8'd255,
    parameter int         TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic [31:0]      base_adr_i,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [SUM_W-1:0] err_sum_o,
    output logic [ERR_W-1:0] err_max_o
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_gap;
    logic [31:0] r_wait;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_prod;

    logic w_stb_act;
    logic w_ack;
    logic w_tmo;
    logic w_start;
    logic w_chk;
    logic w_unused_dat;

    assign w_stb_act    = ((r_state == ST_WR) || (r_state == ST_RD)) && !r_gap;
    assign w_ack        = w_stb_act && wbm_ack_i;
    // An ack on the expiry cycle wins over the timeout.
    assign w_tmo        = w_stb_act && !wbm_ack_i && (r_wait == 32'(TIMEOUT - 1));
    assign w_start      = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_chk        = (r_state == ST_CHK);
    assign w_unused_dat = ^wbm_dat_i[31:16];
    assign wbm_sel_o    = 4'hF;

    always_comb begin
        w_state_nxt = r_state;
        wbm_cyc_o   = 1'b0;
        wbm_stb_o   = 1'b0;
        wbm_we_o    = 1'b0;
        wbm_adr_o   = 32'd0;
        wbm_dat_o   = 32'd0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_nxt = ST_WR;
            end
            ST_WR: begin
                busy_o    = 1'b1;
                wbm_cyc_o = !r_gap;
                wbm_stb_o = !r_gap;
                wbm_we_o  = !r_gap;
                wbm_adr_o = base_adr_i + OPND_OFS;
                wbm_dat_o = {16'd0, r_a, r_b};
                if (w_ack)      w_state_nxt = ST_RD;
                else if (w_tmo) w_state_nxt = ST_ERR;
            end
            ST_RD: begin
                busy_o    = 1'b1;
                wbm_cyc_o = !r_gap;
                wbm_stb_o = !r_gap;
                wbm_adr_o = base_adr_i + PROD_OFS;
                if (w_ack)      w_state_nxt = ST_CHK;
                else if (w_tmo) w_state_nxt = ST_ERR;
            end
            ST_CHK: begin
                busy_o = 1'b1;
                if ((r_b < B_LAST) || (r_a < A_LAST)) w_state_nxt = ST_WR;
                else                                  w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                if (start_i) w_state_nxt = ST_WR;
            end
            ST_ERR: begin
                err_o = 1'b1;
                if (start_i) w_state_nxt = ST_WR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Every WR/RD entry starts with one cycle of cyc low: the idle gap or the re-arm.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
            r_gap   <= 1'b0;
            r_wait  <= 32'd0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_prod  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= ((w_state_nxt == ST_WR) || (w_state_nxt == ST_RD)) && (w_state_nxt != r_state);
            r_wait  <= w_stb_act ? (r_wait + 32'd1) : 32'd0;
            if (w_ack && (r_state == ST_RD)) begin
                r_prod <= wbm_dat_i[15:0];
            end
            if (w_start) begin
                r_a <= 8'd0;
                r_b <= 8'd0;
            end else if (w_chk) begin
                if (r_b < B_LAST) begin
                    r_b <= r_b + 8'd1;
                end else if (r_a < A_LAST) begin
                    r_b <= 8'd0;
                    r_a <= r_a + 8'd1;
                end
            end
        end
    end

    axmul_err_acc u_err_acc (
        .clk            (wb_clk_i),
        .rst_n          (wb_rst_ni),
        .i_clr          (w_start),
        .i_chk          (w_chk),
        .i_a            (r_a),
        .i_b            (r_b),
        .i_prod         (r_prod),
        .o_mismatch_cnt (mismatch_cnt_o),
        .o_err_sum      (err_sum_o),
        .o_err_max      (err_max_o)
    );

endmodule

// File: tb/tb_axmul_wb_sweeper.sv
// Directed bench: 4x4 sweep (A_LAST=B_LAST=3, TIMEOUT=8) against a behavioural Wishbone responder.
module tb_axmul_wb_sweeper;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base = 32'h4000_1000;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat, dat_i;
    logic        busy, done, err;
    logic [16:0] mism;
    logic [31:0] esum;
    logic [15:0] emax;

    always #5 clk = ~clk;

    axmul_wb_sweeper #(.A_LAST(8'd3), .B_LAST(8'd3), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .base_adr_i(base),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
        .busy_o(busy), .done_o(done), .err_o(err),
        .mismatch_cnt_o(mism), .err_sum_o(esum), .err_max_o(emax)
    );

    // Responder modes: 0 exact, 1 bit0 cleared, 2 mixed errors, 3 never ack, 4 exact+1
    int          mode = 0;
    int          ws = 0;
    bit          stray = 1'b0;
    logic [15:0] opnd = 16'd0;
    int          wcnt = 0;
    logic [15:0] prod_e, prod_r;
    int          cyc_cnt = 0;
    int          stb_cycles = 0;
    int          stb_rise_t = 0;
    int          bus_bad = 0;
    logic        prev_stb = 1'b0;
    logic [31:0] wr_dat[$];
    logic [31:0] wr_adr[$];
    int          wr_t[$];
    logic [31:0] rd_adr[$];
    int          rd_t[$];

    int errors = 0;
    int checks = 0;

    always_comb begin
        prod_e = {8'd0, opnd[15:8]} * {8'd0, opnd[7:0]};
        prod_r = prod_e;
        case (mode)
            1: prod_r = prod_e & 16'hFFFE;
            2: begin
                if (opnd == 16'h0101)      prod_r = 16'd2;
                else if (opnd == 16'h0302) prod_r = prod_e ^ 16'h0010;
                else if (opnd == 16'h0303) prod_r = 16'd0;
            end
            4: prod_r = prod_e + 16'd1;
            default: prod_r = prod_e;
        endcase
    end

    assign dat_i = {16'hA5A5, prod_r};
    assign ack   = (cyc && stb && (mode != 3) && (wcnt >= ws)) || (stray && !cyc);

    always @(posedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        prev_stb <= stb;
        if ((cyc !== stb) || (cyc && (sel !== 4'hF))) bus_bad <= bus_bad + 1;
        if (stb && !prev_stb) stb_rise_t <= cyc_cnt;
        if (stb) stb_cycles <= stb_cycles + 1;
        if (cyc && stb) begin
            if (ack) begin
                wcnt <= 0;
                if (we) begin
                    opnd <= dat[15:0];
                    wr_dat.push_back(dat);
                    wr_adr.push_back(adr);
                    wr_t.push_back(cyc_cnt);
                end else begin
                    rd_adr.push_back(adr);
                    rd_t.push_back(cyc_cnt);
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    task automatic clear_logs;
        wr_dat.delete(); wr_adr.delete(); wr_t.delete();
        rd_adr.delete(); rd_t.delete();
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cyc, stb, we, busy, done, err} !== 6'd0) begin
            errors++; $display("FAIL reset_ctrl got=%b want=000000", {cyc, stb, we, busy, done, err});
        end
        checks++;
        if ({adr, dat} !== 64'd0 || sel !== 4'hF) begin
            errors++; $display("FAIL reset_bus adr=%h dat=%h sel=%h want 0/0/f", adr, dat, sel);
        end
        checks++;
        if (mism !== 17'd0 || esum !== 32'd0 || emax !== 16'd0) begin
            errors++; $display("FAIL reset_stats got=%0d/%0d/%0d want 0/0/0", mism, esum, emax);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (cyc !== 1'b0 || busy !== 1'b0 || wr_dat.size() != 0) begin
            errors++; $display("FAIL idle_no_start cyc=%b busy=%b writes=%0d want 0", cyc, busy, wr_dat.size());
        end
    endtask

    task automatic test_exact_sweep;
        bit ok;
        logic [31:0] exp;
        mode = 0; ws = 0; clear_logs();
        pulse_start();
        wait_end(300, ok);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL exact_done ok=%0d done=%b err=%b busy=%b want 1/1/0/0", ok, done, err, busy);
        end
        checks++;
        if (mism !== 17'd0 || esum !== 32'd0 || emax !== 16'd0) begin
            errors++; $display("FAIL exact_stats got=%0d/%0d/%0d want 0/0/0", mism, esum, emax);
        end
        checks++;
        if (wr_dat.size() != 16 || rd_adr.size() != 16) begin
            errors++; $display("FAIL exact_counts wr=%0d rd=%0d want 16/16", wr_dat.size(), rd_adr.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                exp = {16'd0, 8'(k / 4), 8'(k % 4)};
                checks++;
                if (wr_dat[k] !== exp || wr_adr[k] !== base || rd_adr[k] !== base + 32'd4) begin
                    errors++; $display("FAIL exact_pair%0d wdat=%h wadr=%h radr=%h want %h/%h/%h",
                                       k, wr_dat[k], wr_adr[k], rd_adr[k], exp, base, base + 32'd4);
                end
                checks++;
                if ((rd_t[k] - wr_t[k] != 2) || (k > 0 && (wr_t[k] - rd_t[k-1] != 3))) begin
                    errors++; $display("FAIL exact_timing%0d rd-wr=%0d wr-prevrd=%0d want 2/3",
                                       k, rd_t[k] - wr_t[k], (k > 0) ? wr_t[k] - rd_t[k-1] : 3);
                end
            end
        end
    endtask

    task automatic test_bitclear;
        bit ok;
        mode = 1; ws = 1; clear_logs();
        pulse_start();
        wait_end(400, ok);
        checks++;
        if (!ok || done !== 1'b1 || mism !== 17'd4 || esum !== 32'd4 || emax !== 16'd1) begin
            errors++; $display("FAIL bitclear done=%b stats=%0d/%0d/%0d want 1 4/4/1", done, mism, esum, emax);
        end
    endtask

    task automatic test_mixed_waits;
        bit ok;
        mode = 2; ws = 2; stray = 1'b1; clear_logs();
        pulse_start();
        wait_end(500, ok);
        stray = 1'b0;
        checks++;
        if (!ok || done !== 1'b1 || mism !== 17'd3 || esum !== 32'd26 || emax !== 16'd16) begin
            errors++; $display("FAIL mixed done=%b stats=%0d/%0d/%0d want 1 3/26/16", done, mism, esum, emax);
        end
        checks++;
        if (wr_t.size() != 16 || rd_t.size() != 16 || rd_t[5] - wr_t[5] != 4 || wr_t[6] - rd_t[5] != 5) begin
            errors++; $display("FAIL mixed_timing wr=%0d rd=%0d want 16 writes, rd-wr=4, wr-rd=5", wr_t.size(), rd_t.size());
        end
    endtask

    task automatic test_ack_at_timeout;
        bit ok;
        mode = 0; ws = TMO - 1; clear_logs();
        pulse_start();
        wait_end(800, ok);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || wr_dat.size() != 16) begin
            errors++; $display("FAIL ack_at_timeout done=%b err=%b writes=%0d want 1/0/16", done, err, wr_dat.size());
        end
    endtask

    task automatic test_timeout;
        bit ok;
        int n0;
        mode = 1; ws = 0; clear_logs();
        pulse_start();
        for (int i = 0; i < 100 && wr_dat.size() < 8; i++) @(negedge clk);
        mode = 3;
        n0 = stb_cycles;
        wait_end(40, ok);
        checks++;
        if (!ok || err !== 1'b1 || done !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0) begin
            errors++; $display("FAIL timeout_err ok=%0d err=%b done=%b cyc=%b stb=%b want 1/1/0/0/0", ok, err, done, cyc, stb);
        end
        checks++;
        if (stb_cycles - n0 != TMO || cyc_cnt - stb_rise_t > 9) begin
            errors++; $display("FAIL timeout_len stb_cycles=%0d elapsed=%0d want %0d/<=9", stb_cycles - n0, cyc_cnt - stb_rise_t, TMO);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (err !== 1'b1 || cyc !== 1'b0 || mism !== 17'd1 || esum !== 32'd1 || emax !== 16'd1) begin
            errors++; $display("FAIL timeout_freeze err=%b cyc=%b stats=%0d/%0d/%0d want 1/0 1/1/1", err, cyc, mism, esum, emax);
        end
        mode = 0; clear_logs();
        pulse_start();
        wait_end(300, ok);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0 || mism !== 17'd0 || wr_dat.size() != 16) begin
            errors++; $display("FAIL timeout_recover done=%b err=%b mism=%0d writes=%0d want 1/0/0/16", done, err, mism, wr_dat.size());
        end
    endtask

    task automatic test_reset_mid;
        mode = 4; ws = 2; clear_logs();
        pulse_start();
        for (int i = 0; i < 100 && !(rd_adr.size() == 2 && cyc && !we); i++) @(negedge clk);
        checks++;
        if (!(cyc && !we) || mism !== 17'd2 || esum !== 32'd2) begin
            errors++; $display("FAIL reset_mid_pre cyc=%b we=%b mism=%0d sum=%0d want 1/0 2/2", cyc, we, mism, esum);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({cyc, stb, we, busy, done, err} !== 6'd0 || {adr, dat} !== 64'd0 || sel !== 4'hF) begin
            errors++; $display("FAIL reset_mid_bus ctrl=%b adr=%h dat=%h sel=%h want 0/0/0/f", {cyc, stb, we, busy, done, err}, adr, dat, sel);
        end
        checks++;
        if (mism !== 17'd0 || esum !== 32'd0 || emax !== 16'd0) begin
            errors++; $display("FAIL reset_mid_stats got=%0d/%0d/%0d want 0/0/0", mism, esum, emax);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wr_dat.size() != 3 || rd_adr.size() != 2 || cyc !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_abort wr=%0d rd=%0d cyc=%b busy=%b want 3/2/0/0", wr_dat.size(), rd_adr.size(), cyc, busy);
        end
    endtask

    task automatic test_start_busy;
        bit ok;
        logic [31:0] exp;
        mode = 0; ws = 0; clear_logs();
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        repeat (12) @(negedge clk);
        pulse_start();
        repeat (15) @(negedge clk);
        pulse_start();
        wait_end(300, ok);
        checks++;
        if (!ok || done !== 1'b1 || wr_dat.size() != 16) begin
            errors++; $display("FAIL busy_start done=%b writes=%0d want 1/16", done, wr_dat.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                exp = {16'd0, 8'(k / 4), 8'(k % 4)};
                checks++;
                if (wr_dat[k] !== exp) begin
                    errors++; $display("FAIL busy_seq%0d got=%h want=%h", k, wr_dat[k], exp);
                end
            end
        end
        checks++;
        if (bus_bad != 0) begin
            errors++; $display("FAIL bus_protocol bad_cycles=%0d want 0", bus_bad);
        end
    endtask

    initial begin
        test_reset();
        test_exact_sweep();
        test_bitclear();
        test_mixed_waits();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
